// File: rtl/decode_issue.sv
// decode_issue: splits one RV64 instruction per handshake into ALU fields and reads both operands.
// Latency: 1 cycle from the accept edge to out_valid. Operands come from a 32x64 file with a writeback bypass.
// Backpressure: in_ready drops while out_ready=0 holds a valid output, or on a RAW hazard against the held instruction.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_instr/in_pc   : fetch-side handshake
//   out_valid/out_ready                : ALU-side handshake
//   regA, regB, opcode, regDest, uimm  : decoded fields of the held instruction
//   o_pc, regA_value, regB_value       : pc and operand values of the held instruction
//   wb_en/wb_rd/wb_data                : registered ALU writeback into the register file
module decode_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  regA,
  output logic [11:0] regB,
  output logic [9:0]  opcode,
  output logic [4:0]  regDest,
  output logic [19:0] uimm,
  output logic [31:0] o_pc,
  output logic [63:0] regA_value,
  output logic [63:0] regB_value,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_data
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH= 7'b1100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_R32   = 7'b0111011;

  logic [63:0] rf [32];

  logic [6:0]  op7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        is_s;
  logic        is_b;
  logic        is_u;
  logic        is_jal;
  logic        is_r;
  logic        uses_rs1;
  logic        uses_rs2;
  logic [11:0] dec_regB;
  logic [19:0] dec_uimm;
  logic [4:0]  dec_rd;
  logic [63:0] rs1_val;
  logic [63:0] rs2_val;
  logic        hazard;
  logic        accept;

  // Field decode of the incoming instruction.
  always_comb begin
    op7      = in_instr[6:0];
    rs1      = in_instr[19:15];
    rs2      = in_instr[24:20];
    is_s     = (op7 == OP_STORE);
    is_b     = (op7 == OP_BRANCH);
    is_u     = (op7 == OP_LUI) || (op7 == OP_AUIPC);
    is_jal   = (op7 == OP_JAL);
    is_r     = (op7 == OP_R) || (op7 == OP_R32);
    uses_rs1 = !(is_u || is_jal);
    uses_rs2 = is_r || is_s || is_b;

    dec_regB = in_instr[31:20];
    if (is_s) dec_regB = {in_instr[31:25], in_instr[11:7]};
    if (is_b) dec_regB = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};

    dec_uimm = '0;
    if (is_u)   dec_uimm = in_instr[31:12];
    if (is_jal) dec_uimm = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]};

    // S/B carry immediate bits in the rd slot; they never write a register.
    dec_rd = (is_s || is_b) ? 5'd0 : in_instr[11:7];
  end

  // Operand read with same-cycle writeback bypass; x0 is hardwired and never bypassed.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0) rs1_val = (wb_en && (wb_rd == rs1)) ? wb_data : rf[rs1];
    if (rs2 != 5'd0) rs2_val = (wb_en && (wb_rd == rs2)) ? wb_data : rf[rs2];
  end

  // regDest of the held instruction is already 0 for S/B and for rd=x0, so a
  // non-zero regDest means "held instruction writes a register".
  always_comb begin
    hazard = out_valid && (regDest != 5'd0) &&
             ((uses_rs1 && (rs1 == regDest)) || (uses_rs2 && (rs2 == regDest)));
    in_ready = (!out_valid || out_ready) && !hazard;
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      regA       <= '0;
      regB       <= '0;
      opcode     <= '0;
      regDest    <= '0;
      uimm       <= '0;
      o_pc       <= '0;
      regA_value <= '0;
      regB_value <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      regA       <= rs1;
      regB       <= dec_regB;
      opcode     <= {in_instr[14:12], op7};
      regDest    <= dec_rd;
      uimm       <= dec_uimm;
      o_pc       <= in_pc;
      regA_value <= rs1_val;
      regB_value <= rs2_val;
    end else if (out_ready) begin
      // Drained with nothing new (idle or hazard): insert a bubble.
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed checks of decode_issue acting as both fetch and ALU.
// Inputs are driven 1ns after the rising edge; outputs are sampled on the falling edge.
// Each task covers one feature and compares inline against hand-computed values.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  regA;
  logic [11:0] regB;
  logic [9:0]  opcode;
  logic [4:0]  regDest;
  logic [19:0] uimm;
  logic [31:0] o_pc;
  logic [63:0] regA_value;
  logic [63:0] regB_value;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .regA(regA), .regB(regB), .opcode(opcode), .regDest(regDest), .uimm(uimm),
    .o_pc(o_pc), .regA_value(regA_value), .regB_value(regB_value),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b1;
    wb_en     = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
  endtask

  task automatic do_wb(input logic [4:0] rd, input logic [63:0] d);
    wb_en = 1'b1; wb_rd = rd; wb_data = d;
    cyc();
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    cyc();
    in_valid = 1'b0; in_instr = '0; in_pc = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
    checks++; if (regA !== 5'd0) begin failures++; $display("FAIL rst_regA got=%0h exp=0", regA); end
    checks++; if (regB !== 12'd0) begin failures++; $display("FAIL rst_regB got=%0h exp=0", regB); end
    checks++; if (opcode !== 10'd0) begin failures++; $display("FAIL rst_opcode got=%0h exp=0", opcode); end
    checks++; if (regDest !== 5'd0) begin failures++; $display("FAIL rst_regDest got=%0h exp=0", regDest); end
    checks++; if (uimm !== 20'd0) begin failures++; $display("FAIL rst_uimm got=%0h exp=0", uimm); end
    checks++; if (o_pc !== 32'd0) begin failures++; $display("FAIL rst_o_pc got=%0h exp=0", o_pc); end
    checks++; if (regA_value !== 64'd0) begin failures++; $display("FAIL rst_regA_value got=%0h exp=0", regA_value); end
    checks++; if (regB_value !== 64'd0) begin failures++; $display("FAIL rst_regB_value got=%0h exp=0", regB_value); end
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_decode();
    // addi x5,x6,-1
    in_valid = 1'b1; in_instr = 32'hFFF30293; in_pc = 32'h100;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL addi_in_ready got=%0h exp=1", in_ready); end
    cyc();
    in_valid = 1'b0; in_instr = '0; in_pc = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_out_valid got=%0h exp=1", out_valid); end
    checks++; if (regA !== 5'd6) begin failures++; $display("FAIL addi_regA got=%0h exp=6", regA); end
    checks++; if (regB !== 12'hFFF) begin failures++; $display("FAIL addi_regB got=%0h exp=fff", regB); end
    checks++; if (opcode !== 10'h013) begin failures++; $display("FAIL addi_opcode got=%0h exp=13", opcode); end
    checks++; if (regDest !== 5'd5) begin failures++; $display("FAIL addi_regDest got=%0h exp=5", regDest); end
    checks++; if (uimm !== 20'd0) begin failures++; $display("FAIL addi_uimm got=%0h exp=0", uimm); end
    checks++; if (o_pc !== 32'h100) begin failures++; $display("FAIL addi_o_pc got=%0h exp=100", o_pc); end
    cyc();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL addi_drain got=%0h exp=0", out_valid); end
    cyc();

    // beq x1,x2,-8 with x2 preloaded
    do_wb(5'd2, 64'hDEAD_BEEF_0000_0002);
    send(32'hFE208CE3, 32'h104);
    @(negedge clk);
    checks++; if (regA !== 5'd1) begin failures++; $display("FAIL beq_regA got=%0h exp=1", regA); end
    checks++; if (regB !== 12'hFFC) begin failures++; $display("FAIL beq_regB got=%0h exp=ffc", regB); end
    checks++; if (opcode !== 10'h063) begin failures++; $display("FAIL beq_opcode got=%0h exp=63", opcode); end
    checks++; if (regDest !== 5'd0) begin failures++; $display("FAIL beq_regDest got=%0h exp=0", regDest); end
    checks++; if (regB_value !== 64'hDEAD_BEEF_0000_0002) begin failures++; $display("FAIL beq_regB_value got=%0h exp=deadbeef00000002", regB_value); end
    cyc();

    // sw x5,12(x6)
    send(32'h00532623, 32'h108);
    @(negedge clk);
    checks++; if (regB !== 12'h00C) begin failures++; $display("FAIL sw_regB got=%0h exp=c", regB); end
    checks++; if (opcode !== 10'h123) begin failures++; $display("FAIL sw_opcode got=%0h exp=123", opcode); end
    checks++; if (regDest !== 5'd0) begin failures++; $display("FAIL sw_regDest got=%0h exp=0", regDest); end
    cyc();

    // jal x1,+2048
    send(32'h001000EF, 32'h10C);
    @(negedge clk);
    checks++; if (uimm !== 20'h00400) begin failures++; $display("FAIL jal_uimm got=%0h exp=400", uimm); end
    checks++; if (opcode !== 10'h06F) begin failures++; $display("FAIL jal_opcode got=%0h exp=6f", opcode); end
    checks++; if (regDest !== 5'd1) begin failures++; $display("FAIL jal_regDest got=%0h exp=1", regDest); end
    cyc();
  endtask

  task automatic test_wb_read();
    do_wb(5'd7, 64'h1234_5678_9ABC_DEF0);
    send(32'h00038433, 32'h200);  // add x8,x7,x0
    @(negedge clk);
    checks++; if (regA !== 5'd7) begin failures++; $display("FAIL wbrd_regA got=%0h exp=7", regA); end
    checks++; if (regDest !== 5'd8) begin failures++; $display("FAIL wbrd_regDest got=%0h exp=8", regDest); end
    checks++; if (regA_value !== 64'h1234_5678_9ABC_DEF0) begin failures++; $display("FAIL wbrd_regA_value got=%0h exp=123456789abcdef0", regA_value); end
    checks++; if (regB_value !== 64'd0) begin failures++; $display("FAIL wbrd_regB_value got=%0h exp=0", regB_value); end
    cyc();
  endtask

  task automatic test_hazard();
    in_valid = 1'b1; in_instr = 32'h00500193; in_pc = 32'h300;  // addi x3,x0,5
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL haz_i1_ready got=%0h exp=1", in_ready); end
    cyc();
    in_instr = 32'h00318233; in_pc = 32'h304;                   // add x4,x3,x3
    @(negedge clk);
    checks++; if (regDest !== 5'd3) begin failures++; $display("FAIL haz_i1_regDest got=%0h exp=3", regDest); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL haz_stall_ready got=%0h exp=0", in_ready); end
    cyc();
    // ALU writes back I1's result in the cycle after consuming it
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 64'd5;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL haz_bubble got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL haz_release_ready got=%0h exp=1", in_ready); end
    cyc();
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    in_valid = 1'b0; in_instr = '0; in_pc = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL haz_i2_valid got=%0h exp=1", out_valid); end
    checks++; if (regDest !== 5'd4) begin failures++; $display("FAIL haz_i2_regDest got=%0h exp=4", regDest); end
    checks++; if (o_pc !== 32'h304) begin failures++; $display("FAIL haz_i2_pc got=%0h exp=304", o_pc); end
    checks++; if (regA_value !== 64'd5) begin failures++; $display("FAIL haz_regA_value got=%0h exp=5", regA_value); end
    checks++; if (regB_value !== 64'd5) begin failures++; $display("FAIL haz_regB_value got=%0h exp=5", regB_value); end
    cyc();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00700513; in_pc = 32'h400;  // addi x10,x0,7
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ia_ready got=%0h exp=1", in_ready); end
    cyc();
    in_instr = 32'h00900593; in_pc = 32'h404;                   // addi x11,x0,9
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d] got=%0h exp=1", k, out_valid); end
      checks++; if (regDest !== 5'd10) begin failures++; $display("FAIL bp_hold_regDest[%0d] got=%0h exp=a", k, regDest); end
      checks++; if (o_pc !== 32'h400) begin failures++; $display("FAIL bp_hold_pc[%0d] got=%0h exp=400", k, o_pc); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready[%0d] got=%0h exp=0", k, in_ready); end
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (regDest !== 5'd10) begin failures++; $display("FAIL bp_issue_a got=%0h exp=a", regDest); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_resume_ready got=%0h exp=1", in_ready); end
    cyc();
    in_valid = 1'b0; in_instr = '0; in_pc = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_issue_b_valid got=%0h exp=1", out_valid); end
    checks++; if (regDest !== 5'd11) begin failures++; $display("FAIL bp_issue_b got=%0h exp=b", regDest); end
    checks++; if (o_pc !== 32'h404) begin failures++; $display("FAIL bp_issue_b_pc got=%0h exp=404", o_pc); end
    cyc();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0h exp=0", out_valid); end
    cyc();
  endtask

  task automatic test_x0();
    do_wb(5'd0, 64'hFF);
    send(32'h00100493, 32'h500);  // addi x9,x0,1
    @(negedge clk);
    checks++; if (regA_value !== 64'd0) begin failures++; $display("FAIL x0_file got=%0h exp=0", regA_value); end
    cyc();
    // wb to x0 in the accept cycle must not bypass
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hFF;
    send(32'h00100493, 32'h504);
    wb_en = 1'b0; wb_data = '0;
    @(negedge clk);
    checks++; if (regA_value !== 64'd0) begin failures++; $display("FAIL x0_bypass got=%0h exp=0", regA_value); end
    cyc();
    in_valid = 1'b1; in_instr = 32'h12345037; in_pc = 32'h508;  // lui x0,0x12345
    cyc();
    in_instr = 32'h00000633; in_pc = 32'h50C;                   // add x12,x0,x0
    @(negedge clk);
    checks++; if (uimm !== 20'h12345) begin failures++; $display("FAIL lui_uimm got=%0h exp=12345", uimm); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL x0_no_stall got=%0h exp=1", in_ready); end
    cyc();
    in_valid = 1'b0; in_instr = '0; in_pc = '0;
    @(negedge clk);
    checks++; if (regDest !== 5'd12) begin failures++; $display("FAIL x0_consumer got=%0h exp=c", regDest); end
    cyc();
  endtask

  task automatic test_midstream_reset();
    out_ready = 1'b0;
    send(32'hFFF30293, 32'h600);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mrst_pre_valid got=%0h exp=1", out_valid); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_async_valid got=%0h exp=0", out_valid); end
    checks++; if (regDest !== 5'd0) begin failures++; $display("FAIL mrst_async_regDest got=%0h exp=0", regDest); end
    cyc();
    reset = 1'b1;
    out_ready = 1'b1;
  endtask

  // Reads every register back to back (add x0,xi,xi): all zero after reset, one per cycle.
  task automatic test_back_to_back();
    logic [4:0] r;
    in_valid = 1'b1;
    for (int i = 1; i < 32; i++) begin
      r = 5'(i);
      in_instr = {7'd0, r, r, 3'd0, 5'd0, 7'b0110011};
      in_pc = 32'(i * 4);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%0h exp=1", i, in_ready); end
      if (i > 1) begin
        checks++; if (regA !== 5'(i - 1)) begin failures++; $display("FAIL b2b_regA[%0d] got=%0h exp=%0h", i, regA, i - 1); end
        checks++; if ({regA_value, regB_value} !== 128'd0) begin failures++; $display("FAIL b2b_vals[%0d] got=%0h/%0h exp=0", i, regA_value, regB_value); end
      end
      cyc();
    end
    in_valid = 1'b0; in_instr = '0; in_pc = '0;
    @(negedge clk);
    checks++; if (regA !== 5'd31) begin failures++; $display("FAIL b2b_last_regA got=%0h exp=1f", regA); end
    checks++; if ({regA_value, regB_value} !== 128'd0) begin failures++; $display("FAIL b2b_last_vals got=%0h/%0h exp=0", regA_value, regB_value); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_wb_read();
    test_hazard();
    test_backpressure();
    test_x0();
    test_midstream_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode-and-issue stage feeding the integer ALU. It accepts one 32-bit RV64 instruction per handshake and splits it into the ALU's field format: regA, regB, 10-bit opcode, regDest and uimm. It reads both source operands from an internal 32x64 register file, which is written by the ALU's registered writeback port. A one-entry output register holds the decoded instruction. The block detects read-after-write hazards against the instruction in that register and stalls issue until the result can be bypassed.

## Interface
- No parameters; XLEN fixed at 64, 32 architectural registers.
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_instr  in  32  raw instruction word
- in_pc  in  32  instruction address
- out_valid  out  1  decoded instruction valid to ALU
- out_ready  in  1  ALU consumes output this cycle
- regA  out  5  rs1 = instr[19:15]
- regB  out  12  type-dependent immediate/funct7+rs2 field (see Operation)
- opcode  out  10  {instr[14:12], instr[6:0]}
- regDest  out  5  rd = instr[11:7]; 0 for S/B types
- uimm  out  20  U: instr[31:12]; J: {instr[31], instr[19:12], instr[20], instr[30:21]}
- o_pc  out  32  in_pc of decoded instruction
- regA_value  out  64  rs1 operand
- regB_value  out  64  rs2 operand (rs2 = instr[24:20])
- wb_en  in  1  ALU writeback strobe
- wb_rd  in  5  writeback destination
- wb_data  in  64  writeback value

## Operation
- regB by opcode7:
  - I-type and R-type: instr[31:20]. For R-type this gives funct7 in [11:5] and rs2 in [4:0].
  - S (0100011): {instr[31:25], instr[11:7]}.
  - B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8]}, i.e. imm[12:1].
- uimm: U-type (0110111, 0010111) and JAL (1101111) use the mappings above; all other types give 0.
- Source use:
  - uses_rs1: every opcode except LUI, AUIPC, JAL.
  - uses_rs2: R-type (0110011, 0111011), S, B.
- Writes rd: every opcode except S and B, and only when rd != 0.
- Register file: 32x64 flops.
  - Write at the clock edge when wb_en=1 and wb_rd != 0.
  - x0 always reads 0.
- Operand read is combinational at accept time.
  - If wb_en=1, wb_rd == src and src != 0, the operand takes wb_data (same-cycle bypass).
  - Otherwise it takes the file contents.
- Hazard: out_valid=1, the held instruction writes rd, and the incoming instruction uses rs1 or rs2 equal to that rd.
- Accept condition: in_valid && in_ready, where in_ready = (!out_valid || out_ready) && !hazard.
- Output register update per cycle:
  - accept: load all fields and operand values; out_valid=1.
  - else if out_ready: out_valid=0 (bubble). This includes the hazard case.
  - else: hold every field unchanged.
- Unknown opcodes are decoded by the same field rules and issued unchanged; legality is checked downstream.

## Timing
- Reset: out_valid=0; regA, regB, opcode, regDest, uimm, o_pc, regA_value, regB_value = 0; all 32 registers = 0. in_ready follows its equation (1 after reset).
- Reset asserted mid-operation: the held instruction and the register file are discarded asynchronously.
- Decode latency: 1 cycle, accept edge to out_valid.
- Back-to-back independent instructions: 1 per cycle while out_ready=1.
- Dependent pair: exactly 1 bubble. Sequence for consumer I2 of I1:
  - Cycle N: I1 held, hazard, I2 not accepted.
  - Edge N+1: the ALU registers I1's result; the output register empties.
  - Cycle N+1: I2 is accepted with wb_data bypassed.
- Simultaneous wb write and read of the same register: the read returns the new value via bypass. The file is updated at the same edge.
- wb to x0: ignored; reads of x0 are never bypassed.
- out_ready=0 with out_valid=1: outputs stable, in_ready=0.

## Test plan
- Reset: drive reset=0 mid-stream with out_valid=1 -> out_valid=0 immediately; after release, every register reads 0.
- Field decode:
  - addi x5,x6,-1 (0xFFF30293) -> regA=6, regB=0xFFF, opcode=0x013, regDest=5.
  - beq x1,x2,-8 (0xFE208CE3) -> regB=0xFFC, regDest=0, regB_value=x2.
- Writeback/read: wb x7=0x1234_5678_9ABC_DEF0, then add x8,x7,x0 -> regA_value=0x123456789ABCDEF0.
- Hazard: addi x3,x0,5 then add x4,x3,x3 on consecutive cycles -> one bubble (in_ready=0 for 1 cycle); the second issues with regA_value=regB_value=5 via wb bypass.
- Backpressure: out_ready=0 for 3 cycles with 2 instructions queued -> outputs frozen, in_ready=0; then both issue in order on consecutive cycles.
- x0 protection: wb_en=1, wb_rd=0, wb_data=0xFF -> a later read of x0 gives 0; lui x0 followed by a consumer of x0 -> no stall.
